// File: rtl/config_reg_bank.sv
// rtl/config_reg_bank.sv - parametrised configuration register bank with byte lanes, RO mask and sticky lock
//
// Purpose: NUM_REGS x DATA_W configuration registers between the host port and datapath consumers.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset, overrides any access in the same cycle
//   write     in   write request
//   read      in   read request (one-cycle latency)
//   address   in   register address for read and write
//   data_in   in   write data
//   byte_en   in   write byte-lane enables, lane k = data_in[8k+7:8k]
//   data_out  out  registered read data, holds when no read
//   rd_valid  out  pulse: data_out carries the previous cycle's read
//   err       out  pulse: previous cycle's access was rejected
//   locked    out  current sticky lock bit
module config_reg_bank #(
  parameter int                          DATA_W    = 16,
  parameter int                          ADDR_W    = 3,
  parameter int                          NUM_REGS  = 8,
  parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL = '0,
  parameter logic [NUM_REGS-1:0]         RO_MASK   = '0,
  parameter int                          LOCK_ADDR = NUM_REGS - 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic                  read,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W/8-1:0]   byte_en,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid,
  output logic                  err,
  output logic                  locked
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_valid_q, rd_valid_d;
  logic              err_q, err_d;

  logic              addr_hit;
  logic              ro_hit;
  logic              lock_sel;
  logic              wr_ok;
  logic [DATA_W-1:0] rd_word;

  // The lock bit lives in bit 0 of the lock register, so a read of that
  // register reports it and the remaining bits behave as plain storage.
  assign locked = regs_q[LOCK_ADDR][0];

  always_comb begin
    addr_hit = 1'b0;
    ro_hit   = 1'b0;
    rd_word  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (address == ADDR_W'(i)) begin
        addr_hit = 1'b1;
        ro_hit   = RO_MASK[i];
        rd_word  = regs_q[i];
      end
    end

    lock_sel = (address == ADDR_W'(LOCK_ADDR));
    // The lock register itself stays writable while locked so its other bits remain usable.
    wr_ok    = write && addr_hit && !ro_hit && (!locked || lock_sel);

    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_ok && address == ADDR_W'(i)) begin
        for (int k = 0; k < NB; k++) begin
          if (byte_en[k]) regs_d[i][8*k +: 8] = data_in[8*k +: 8];
        end
      end
    end
    // Sticky: once set, only reset can clear it.
    regs_d[LOCK_ADDR][0] = regs_q[LOCK_ADDR][0]
                         | (wr_ok && lock_sel && byte_en[0] && data_in[0]);

    // rd_word is already zero for out-of-range addresses; reads sample pre-write state.
    data_out_d = read ? rd_word : data_out_q;
    rd_valid_d = read;
    err_d      = (write && !wr_ok) || (read && !addr_hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL[i*DATA_W +: DATA_W];
      end
      regs_q[LOCK_ADDR][0] <= 1'b0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;

endmodule
